// File: rtl/sim_mon.sv
// sim_mon: end-of-test monitor. Checks reset length, collects per-agent done requests,
// runs an inactivity watchdog and raises a sticky finish request. Trace: EXM_SIM_MON_TRACE_EN.
module sim_mon #(
   parameter int REQS       = 4,
   parameter int RST_MIN    = 5,
   parameter int IDLE_LIMIT = 1000,
   parameter int DRAIN      = 16
) (
   input  logic            sim_mon_clk_ip,
   input  logic            sim_mon_rst_ip,
   input  logic [REQS-1:0] sim_mon_done_req_ip,
   output logic [REQS-1:0] sim_mon_done_ack_op,
   input  logic            sim_mon_activity_ip,
   output logic            sim_mon_finish_op,
   output logic            sim_mon_error_op,
   output logic [1:0]      sim_mon_error_code_op,
   output logic [31:0]     sim_mon_cycles_op,
   output logic [1:0]      sim_mon_state_op
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   localparam logic [31:0] LP_RST_MIN    = 32'(RST_MIN);
   localparam logic [31:0] LP_IDLE_LIMIT = 32'(IDLE_LIMIT);
   localparam logic [31:0] LP_DRAIN      = 32'(DRAIN);

   state_t          r_state;
   logic [REQS-1:0] r_ack;
   logic [REQS-1:0] r_ack_d;
   logic [REQS-1:0] r_req_prev;
   logic [REQS-1:0] r_done_seen;
   logic            r_finish;
   logic            r_error;
   logic [1:0]      r_code;
   logic [31:0]     r_cycles;
   logic [31:0]     r_idle;
   logic [31:0]     r_drain;
   logic [31:0]     r_rst_len;

   logic [REQS-1:0] w_elig;
   logic [REQS-1:0] w_grant;
   logic [REQS-1:0] w_drop;
   logic            w_all_done;
   logic            w_busy;
   logic            w_idle_trip;
   logic [31:0]     w_idle_inc;
   logic [31:0]     w_cycles_inc;
   logic [1:0]      w_err_code;

   // An agent still showing its ack this cycle is not eligible again until the ack drops.
   assign w_elig       = sim_mon_done_req_ip & ~r_ack;
   // A drop is only legal once the ack was visible in the cycle before the drop.
   assign w_drop       = r_req_prev & ~sim_mon_done_req_ip & ~r_ack_d;
   assign w_all_done   = &(r_done_seen | w_grant);
   assign w_busy       = sim_mon_activity_ip | (|sim_mon_done_req_ip);
   assign w_idle_inc   = (r_idle >= LP_IDLE_LIMIT) ? LP_IDLE_LIMIT : r_idle + 32'd1;
   assign w_idle_trip  = !w_busy && (w_idle_inc >= LP_IDLE_LIMIT);
   assign w_cycles_inc = (r_cycles == 32'hFFFF_FFFF) ? r_cycles : r_cycles + 32'd1;

   always_comb begin
      logic v_found;
      v_found = 1'b0;
      w_grant = '0;
      for (int i = 0; i < REQS; i++) begin
         if (w_elig[i] && !v_found) begin
            w_grant[i] = 1'b1;
            v_found    = 1'b1;
         end
      end
   end

   // All-done beats a coincident watchdog trip; otherwise the lowest code wins.
   always_comb begin
      w_err_code = 2'd0;
      case (r_state)
         S_IDLE: begin
            if (r_rst_len < LP_RST_MIN) w_err_code = 2'd1;
         end
         S_RUN: begin
            if (w_idle_trip && !w_all_done) w_err_code = 2'd2;
            else if (|w_drop)               w_err_code = 2'd3;
         end
         S_DRAIN: begin
            if (|w_drop) w_err_code = 2'd3;
         end
         default: w_err_code = 2'd0;
      endcase
   end

   // Reset length is measured across reset, so this counter ignores it as a clear.
   always_ff @(posedge sim_mon_clk_ip) begin
      if (sim_mon_rst_ip) begin
         r_rst_len <= (r_rst_len >= LP_RST_MIN) ? LP_RST_MIN : r_rst_len + 32'd1;
      end else begin
         r_rst_len <= '0;
      end
   end

   always_ff @(posedge sim_mon_clk_ip) begin
      if (sim_mon_rst_ip) begin
         r_state     <= S_IDLE;
         r_ack       <= '0;
         r_ack_d     <= '0;
         r_req_prev  <= '0;
         r_done_seen <= '0;
         r_finish    <= 1'b0;
         r_error     <= 1'b0;
         r_code      <= 2'd0;
         r_cycles    <= '0;
         r_idle      <= '0;
         r_drain     <= '0;
      end else begin
         r_req_prev <= sim_mon_done_req_ip;
         r_ack_d    <= r_ack;
         r_ack      <= '0;
         if ((w_err_code != 2'd0) && !r_error) begin
            r_error <= 1'b1;
            r_code  <= w_err_code;
         end
         case (r_state)
            S_IDLE: begin
               r_state <= S_RUN;
            end
            S_RUN: begin
               r_ack       <= w_grant;
               r_done_seen <= r_done_seen | w_grant;
               r_cycles    <= w_cycles_inc;
               r_idle      <= w_busy ? 32'd0 : w_idle_inc;
               if (w_all_done || w_idle_trip) begin
                  r_drain <= LP_DRAIN;
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               r_ack       <= w_grant;
               r_done_seen <= r_done_seen | w_grant;
               r_cycles    <= w_cycles_inc;
               if (r_drain <= 32'd1) begin
                  r_state  <= S_FINISH;
                  r_finish <= 1'b1;
               end else begin
                  r_drain <= r_drain - 32'd1;
               end
            end
            S_FINISH: begin
               r_state <= S_FINISH;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign sim_mon_done_ack_op   = r_ack;
   assign sim_mon_finish_op     = r_finish;
   assign sim_mon_error_op      = r_error;
   assign sim_mon_error_code_op = r_code;
   assign sim_mon_cycles_op     = r_cycles;
   assign sim_mon_state_op      = r_state;

`ifdef EXM_SIM_MON_TRACE_EN
   state_t      r_trc_state;
   logic        r_trc_error;
   logic [31:0] r_trc_agent;
   logic [31:0] w_drop_idx;

   always_comb begin
      logic v_hit;
      v_hit      = 1'b0;
      w_drop_idx = '0;
      for (int i = 0; i < REQS; i++) begin
         if (w_drop[i] && !v_hit) begin
            w_drop_idx = 32'(i);
            v_hit      = 1'b1;
         end
      end
   end

   always_ff @(posedge sim_mon_clk_ip) begin
      r_trc_state <= r_state;
      r_trc_error <= r_error;
      r_trc_agent <= w_drop_idx;
      if (r_trc_state != r_state)
         $display("%0t %m: state %s -> %s", $time, r_trc_state.name(), r_state.name());
      if (r_error && !r_trc_error)
         $display("%0t %m: error code %0d agent %0d", $time, r_code, r_trc_agent);
   end
`else
   // Trace disabled: no display logic in this build.
`endif

endmodule

// File: tb/tb_sim_mon.sv
// Testbench for sim_mon: randomized agents/heartbeat checked every cycle against an
// event-level reference model, plus directed reset, drop, watchdog and drain scenarios.
module tb_sim_mon;

   localparam int REQS       = 4;
   localparam int RST_MIN    = 5;
   localparam int IDLE_LIMIT = 1000;
   localparam int DRAIN      = 7;

   localparam int MD_IDLE   = 0;
   localparam int MD_RUN    = 1;
   localparam int MD_DRAIN  = 2;
   localparam int MD_FINISH = 3;

   // ---------------- clock / DUT ----------------
   logic            clk = 1'b0;
   logic            rst;
   logic [REQS-1:0] req;
   logic [REQS-1:0] ack;
   logic            act;
   logic            finish;
   logic            error;
   logic [1:0]      code;
   logic [31:0]     cycles;
   logic [1:0]      state;

   always #5 clk = ~clk;

   sim_mon #(
      .REQS       (REQS),
      .RST_MIN    (RST_MIN),
      .IDLE_LIMIT (IDLE_LIMIT),
      .DRAIN      (DRAIN)
   ) u_dut (
      .sim_mon_clk_ip        (clk),
      .sim_mon_rst_ip        (rst),
      .sim_mon_done_req_ip   (req),
      .sim_mon_done_ack_op   (ack),
      .sim_mon_activity_ip   (act),
      .sim_mon_finish_op     (finish),
      .sim_mon_error_op      (error),
      .sim_mon_error_code_op (code),
      .sim_mon_cycles_op     (cycles),
      .sim_mon_state_op      (state)
   );

   // ---------------- scoreboard / counters ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [REQS-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int              m_t = 0;
   int              m_rst_len = 0;
   int              m_mode = MD_IDLE;
   int              m_last_busy = 0;
   int              m_finish_at = 0;
   int              m_done_cnt = 0;
   bit              m_done[REQS];
   logic [REQS-1:0] m_ack = '0;
   logic [REQS-1:0] m_ack_prev = '0;
   logic [REQS-1:0] m_req_prev = '0;
   logic            m_finish = 1'b0;
   logic            m_err = 1'b0;
   logic [1:0]      m_code = 2'd0;
   logic [31:0]     m_cycles = '0;

   // Advance the model over the coming clock edge using the inputs currently applied.
   task automatic model_step();
      int              first_err;
      int              grant;
      bit              dropped;
      logic [REQS-1:0] new_ack;
      m_t++;
      if (rst) begin
         if (m_rst_len < RST_MIN) m_rst_len++;
         m_mode     = MD_IDLE;
         m_ack      = '0;
         m_ack_prev = '0;
         m_req_prev = '0;
         m_finish   = 1'b0;
         m_err      = 1'b0;
         m_code     = 2'd0;
         m_cycles   = '0;
         m_done_cnt = 0;
         for (int i = 0; i < REQS; i++) m_done[i] = 1'b0;
      end else begin
         first_err = 0;
         grant     = -1;
         dropped   = 1'b0;
         new_ack   = '0;
         if (m_mode == MD_IDLE) begin
            if (m_rst_len < RST_MIN) first_err = 1;
            m_mode      = MD_RUN;
            m_last_busy = m_t;
         end else if (m_mode == MD_RUN || m_mode == MD_DRAIN) begin
            for (int i = 0; i < REQS; i++)
               if (grant < 0 && req[i] && !m_ack[i]) grant = i;
            if (grant >= 0) begin
               new_ack[grant] = 1'b1;
               if (!m_done[grant]) begin
                  m_done[grant] = 1'b1;
                  m_done_cnt++;
               end
            end
            if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
            for (int i = 0; i < REQS; i++)
               if (m_req_prev[i] && !req[i] && !m_ack_prev[i]) dropped = 1'b1;
            if (m_mode == MD_RUN) begin
               if (act || (req != '0)) m_last_busy = m_t;
               if (m_done_cnt == REQS) begin
                  m_mode      = MD_DRAIN;
                  m_finish_at = m_t + DRAIN;
               end else if (m_t - m_last_busy >= IDLE_LIMIT) begin
                  first_err   = 2;
                  m_mode      = MD_DRAIN;
                  m_finish_at = m_t + DRAIN;
               end
            end else if (m_t == m_finish_at) begin
               m_mode   = MD_FINISH;
               m_finish = 1'b1;
            end
            if (dropped && first_err == 0) first_err = 3;
         end
         if (first_err != 0 && !m_err) begin
            m_err  = 1'b1;
            m_code = 2'(first_err);
         end
         m_ack_prev = m_ack;
         m_ack      = new_ack;
         m_req_prev = req;
         m_rst_len  = 0;
      end
      exp_q.push_back(m_ack);
   endtask

   task automatic check_all();
      logic [REQS-1:0] e_ack;
      e_ack = exp_q.pop_front();
      check("ack",    32'(ack),    32'(e_ack));
      check("finish", 32'(finish), 32'(m_finish));
      check("error",  32'(error),  32'(m_err));
      check("code",   32'(code),   32'(m_code));
      check("cycles", cycles,      m_cycles);
   endtask

   // ---------------- driver ----------------
   logic [REQS-1:0] a_drop_next = '0;
   int g_raise_pct = 0;
   int g_act_pct   = 0;
   int g_bad_pct   = 0;

   // Agents hold req through the ack cycle, release the cycle after, and may re-raise.
   task automatic drive_next();
      for (int i = 0; i < REQS; i++) begin
         if (a_drop_next[i]) begin
            req[i]         = 1'b0;
            a_drop_next[i] = 1'b0;
         end else if (req[i]) begin
            if (ack[i])                                    a_drop_next[i] = 1'b1;
            else if (32'($urandom_range(99)) < g_bad_pct)  req[i] = 1'b0;
         end else if (32'($urandom_range(99)) < g_raise_pct) begin
            req[i] = 1'b1;
         end
      end
      act = (32'($urandom_range(99)) < g_act_pct);
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
      drive_next();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         req         = '0;
         a_drop_next = '0;
         cycle();
      end
      req         = '0;
      a_drop_next = '0;
      rst         = 1'b0;
   endtask

   task automatic set_mix(input int raise_pct, input int act_pct, input int bad_pct);
      g_raise_pct = raise_pct;
      g_act_pct   = act_pct;
      g_bad_pct   = bad_pct;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      req = '0;
      act = 1'b0;

      // Long first reset, then a clean randomized run.
      set_mix(10, 100, 0);
      do_reset(8);
      run(60);

      // Too-short reset: error code 1, monitor still proceeds.
      set_mix(10, 100, 0);
      do_reset(3);
      run(40);
      check("short_rst_error", 32'(error), 32'd1);
      check("short_rst_code",  32'(code),  32'd1);

      // All four agents request together in cycle 10.
      set_mix(0, 100, 0);
      do_reset(5);
      run(9);
      req = '1;
      run(4 + DRAIN + 4);
      check("all_done_finish", 32'(finish), 32'd1);
      check("all_done_error",  32'(error),  32'd0);
      check("all_done_state",  32'(state),  32'd3);

      // Watchdog: no activity, no requests.
      set_mix(0, 0, 0);
      do_reset(5);
      run(IDLE_LIMIT + DRAIN + 5);
      check("wdog_error",  32'(error),  32'd1);
      check("wdog_code",   32'(code),   32'd2);
      check("wdog_finish", 32'(finish), 32'd1);

      // Reset while draining with an error set, then a clean run.
      set_mix(0, 0, 0);
      do_reset(5);
      run(IDLE_LIMIT + 3);
      rst = 1'b1;
      cycle();
      check("mid_rst_ack",    32'(ack),    32'd0);
      check("mid_rst_finish", 32'(finish), 32'd0);
      check("mid_rst_error",  32'(error),  32'd0);
      check("mid_rst_code",   32'(code),   32'd0);
      check("mid_rst_cycles", cycles,      32'd0);
      do_reset(4);
      set_mix(20, 100, 0);
      run(80);
      check("post_rst_error",  32'(error),  32'd0);
      check("post_rst_finish", 32'(finish), 32'd1);

      // Agent 2 drops its request before being acked.
      set_mix(0, 100, 0);
      do_reset(5);
      run(3);
      req = 4'b0111;
      cycle();
      req[2] = 1'b0;
      run(2);
      check("drop_error",  32'(error),  32'd1);
      check("drop_code",   32'(code),   32'd3);
      check("drop_finish", 32'(finish), 32'd0);
      req[2] = 1'b1;
      req[3] = 1'b1;
      run(DRAIN + 12);
      check("drop_late_finish", 32'(finish), 32'd1);
      check("drop_late_code",   32'(code),   32'd3);

      // Randomized runs, including occasional illegal drops.
      for (int k = 0; k < 6; k++) begin
         set_mix(int'($urandom_range(25, 3)), int'($urandom_range(100, 60)),
                 int'($urandom_range(3, 0)));
         do_reset(int'($urandom_range(8, 1)));
         run(150);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
